arc4_encrypt: RTL and testbench
===============================

// Module: arc4_encrypt
// PURPOSE
//  ARC4 encryptor: the writer side of the ciphertext memory that the key cracker reads.
//  Reads a length-prefixed plaintext from pt memory and encrypts it under a 24-bit key.
//  Writes the length-prefixed ciphertext into ct memory in the same format the cracker expects.
//  Sits beside ct_mem on the DE1-SoC top and uses the same rdy/en start handshake as the cracker.
// PARAMETERS
//  KEY_BYTES   3    key length in bytes; key[23:16] is key byte 0
//  ADDR_W      8    address width of the pt, ct and S memories (256 entries each)
// PORTS
//  clk        in   1   system clock (CLOCK_50); all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  en         in   1   start request; sampled only while rdy=1
//  rdy        out  1   1 = idle and able to accept en
//  key        in   24  encryption key; latched on the accepted-en cycle
//  pt_addr    out  8   plaintext memory address (sync read, 1-cycle latency)
//  pt_rddata  in   8   plaintext memory read data
//  ct_addr    out  8   ciphertext memory address
//  ct_wrdata  out  8   ciphertext write data
//  ct_wren    out  1   ciphertext write strobe; exactly one byte is written per asserted cycle
// BEHAVIOUR
//  Reset: state=IDLE, rdy=1, ct_wren=0, ct_addr=0, pt_addr=0, ct_wrdata=0; S RAM contents are not cleared.
//  Handshake: start is accepted when en=1 and rdy=1 on the same edge.
//   On that edge key is latched and rdy drops on the next cycle.
//   en is ignored while rdy=0, and key changes after acceptance have no effect.
//   rdy returns to 1 one cycle after the final ct write.
//   If en is held high, a new run starts on the first rdy=1 cycle.
//  States: IDLE -> INIT -> KSA -> LEN -> PRGA -> DONE -> IDLE.
//   INIT: S[i]=i for i=0..255, one write per cycle (256 cycles); always runs, so stale S is irrelevant.
//   KSA: for i=0..255: j=(j+S[i]+key_byte[i mod 3]) mod 256, then swap S[i],S[j]; 6 cycles per i.
//   LEN: read pt[0]=L, then write ct[0]=L (ct_wren for 1 cycle).
//   PRGA: i=j=0; for k=1..L:
//    i=i+1; j=j+S[i]; swap S[i],S[j];
//    pad=S[(S[i]+S[j]) mod 256];
//    write ct[k]=pt[k]^pad; 8 cycles per byte.
//   DONE: 1 cycle, then IDLE.
//  All index arithmetic is 8-bit and wraps mod 256 with no carry out.
//   i wraps 255->0 in KSA; L=255 reaches k=255 with no overflow.
//  L=0: the only write is ct[0]=0; PRGA is skipped; DONE follows LEN.
//  i==j swap: read-both-then-write-both ordering, so S[i] is unchanged; no RAM read-during-write hazard.
//  Total latency from accept to rdy=1 is at most 256+6*256+8*L+8 cycles; benches check this bound only.
//  Reset mid-run: IDLE on the next edge, ct_wren=0 at once, and no further writes; a partial ct image is acceptable.
//  Simultaneous rst and en: rst wins and the run does not start.
// STRUCTURE
//  arc4_pkg:
//   state_t enum {IDLE,INIT,KSA,LEN,PRGA,DONE}
//   KEY_BYTES, ADDR_W, and the KSA_CYC=6 / PRGA_CYC=8 step counts
//   function key_byte(key,i) returning key[23-8*(i%3) -: 8]
//  Sub-module arc4_s_ram: 256x8 single-port sync RAM, 1-cycle read latency, write-first disabled.
//   Instantiated once for S; the FSM plus sub-step counter live in arc4_encrypt.
// TESTING
//  1 Known vector: key=24'h4B6579 ("Key"), pt="\x09Plaintext"
//    -> ct = 09 BB F3 16 E8 D9 40 AF 0A D3; exactly 10 writes.
//  2 Length zero: pt[0]=0, any key -> a single write ct[0]=00, then rdy=1 within 256+1536+8 cycles.
//  3 Reset mid-KSA: assert rst for 1 cycle about 500 cycles after accept
//    -> rdy=1 next cycle, no ct_wren afterwards;
//    rerun with vector 1 -> identical ct.
//  4 en while busy: pulse en and change key to 24'hFFFFFF during PRGA
//    -> output still matches vector 1 and no second run occurs.
//  5 en held high: vector 1 runs twice back to back -> both images identical, with rdy=1 for exactly 1 cycle between.
//  6 Round trip: L=255 random pt, key=24'h000018 -> decrypting ct with a bench ARC4 model recovers pt;
//    ct_addr covers 0..255 once each.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 encryptor.
// The encryptor writes length-prefixed ciphertext in the layout the key cracker reads.
package arc4_pkg;
    localparam int KEY_BYTES = 3;
    localparam int ADDR_W    = 8;
    localparam int KSA_CYC   = 6;
    localparam int PRGA_CYC  = 8;

    typedef enum logic [2:0] {IDLE, INIT, KSA, LEN, PRGA, DONE} state_t;

    // Key byte 0 sits in the most significant byte of the key word.
    function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                            input logic [ADDR_W-1:0] i);
        int n;
        n = int'(i) % KEY_BYTES;
        return key[8*KEY_BYTES-1-8*n -: 8];
    endfunction
endpackage

// File: rtl/arc4_s_ram.sv
// 256x8 single-port synchronous RAM holding the ARC4 state array S.
// A write cycle returns the old contents on rddata (read-first).
module arc4_s_ram
    import arc4_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wrdata,
    input  logic              wren,
    output logic [7:0]        rddata
);
    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wren)
            mem[addr] <= wrdata;
        rddata <= mem[addr];
    end
endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads length-prefixed plaintext, writes length-prefixed ciphertext.
// One FSM with a sub-step counter sequences every S RAM access through registered controls.
module arc4_encrypt
    import arc4_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [ADDR_W-1:0]      pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [ADDR_W-1:0]      ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);
    state_t                 state;
    logic [2:0]             sub;
    logic [8*KEY_BYTES-1:0] key_r;
    logic [7:0]             i, j, k, len, si, sj, t, ptb;
    logic [ADDR_W-1:0]      s_addr;
    logic [7:0]             s_wd, s_rd;
    logic                   s_we;
    logic [7:0]             ksa_j, prga_j, pad_idx, pad;

    arc4_s_ram u_s (
        .clk    (clk),
        .addr   (s_addr),
        .wrdata (s_wd),
        .wren   (s_we),
        .rddata (s_rd)
    );

    // The pad byte is read before the swap lands in RAM, so forward the swapped values.
    always_comb begin
        ksa_j   = j + s_rd + key_byte(key_r, i);
        prga_j  = j + s_rd;
        pad_idx = si + s_rd;
        pad     = s_rd;
        if (t == j)
            pad = si;
        else if (t == i)
            pad = sj;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            sub       <= '0;
            key_r     <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            len       <= '0;
            si        <= '0;
            sj        <= '0;
            t         <= '0;
            ptb       <= '0;
            s_addr    <= '0;
            s_wd      <= '0;
            s_we      <= 1'b0;
            pt_addr   <= '0;
            ct_addr   <= '0;
            ct_wrdata <= '0;
            ct_wren   <= 1'b0;
        end else begin
            s_we    <= 1'b0;
            ct_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && rdy) begin
                        key_r <= key;
                        rdy   <= 1'b0;
                        i     <= '0;
                        sub   <= '0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    s_addr <= i;
                    s_wd   <= i;
                    s_we   <= 1'b1;
                    i      <= i + 8'd1;
                    if (i == 8'hFF) begin
                        j     <= '0;
                        sub   <= '0;
                        state <= KSA;
                    end
                end
                KSA: begin
                    sub <= (sub == 3'(KSA_CYC-1)) ? 3'd0 : sub + 3'd1;
                    case (sub)
                        3'd0: s_addr <= i;
                        3'd2: begin
                            si     <= s_rd;
                            j      <= ksa_j;
                            s_addr <= ksa_j;
                        end
                        3'd4: begin
                            s_addr <= i;
                            s_wd   <= s_rd;
                            s_we   <= 1'b1;
                        end
                        3'd5: begin
                            s_addr <= j;
                            s_wd   <= si;
                            s_we   <= 1'b1;
                            i      <= i + 8'd1;
                            if (i == 8'hFF)
                                state <= LEN;
                        end
                        default: ;
                    endcase
                end
                LEN: begin
                    sub <= sub + 3'd1;
                    case (sub)
                        3'd0: pt_addr <= '0;
                        3'd2: begin
                            len       <= pt_rddata;
                            ct_addr   <= '0;
                            ct_wrdata <= pt_rddata;
                            ct_wren   <= 1'b1;
                        end
                        3'd3: begin
                            i     <= '0;
                            j     <= '0;
                            k     <= 8'd1;
                            sub   <= '0;
                            state <= (len == 8'd0) ? DONE : PRGA;
                        end
                        default: ;
                    endcase
                end
                PRGA: begin
                    sub <= sub + 3'd1;
                    case (sub)
                        3'd0: begin
                            i       <= i + 8'd1;
                            s_addr  <= i + 8'd1;
                            pt_addr <= k;
                        end
                        3'd2: begin
                            si     <= s_rd;
                            j      <= prga_j;
                            s_addr <= prga_j;
                            ptb    <= pt_rddata;
                        end
                        3'd4: begin
                            sj     <= s_rd;
                            t      <= pad_idx;
                            s_addr <= pad_idx;
                        end
                        3'd5: begin
                            s_addr <= i;
                            s_wd   <= sj;
                            s_we   <= 1'b1;
                        end
                        3'd6: begin
                            s_addr    <= j;
                            s_wd      <= si;
                            s_we      <= 1'b1;
                            ct_addr   <= k;
                            ct_wrdata <= ptb ^ pad;
                            ct_wren   <= 1'b1;
                        end
                        default: begin
                            if (sub == 3'(PRGA_CYC-1)) begin
                                k <= k + 8'd1;
                                if (k == len)
                                    state <= DONE;
                            end
                        end
                    endcase
                end
                DONE: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arc4_encrypt.sv
// Scoreboard bench for arc4_encrypt: expected ct writes are queued at stimulus time
// and a forked monitor pops and compares each observed ct write.
module tb_arc4_encrypt;
    logic        clk = 1'b0;
    logic        rst, en, rdy, ct_wren;
    logic [23:0] key;
    logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;

    logic [7:0]  pt_mem [256];
    logic [7:0]  ct_mem [256];
    logic [7:0]  dec    [256];
    int          seen   [256];
    logic [15:0] exp_q  [$];
    int          checks = 0, errors = 0, nwr = 0;

    logic [7:0] kv_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] kv_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    always #10 clk = ~clk;
    always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

    arc4_encrypt dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    // Reference ARC4: plain textbook algorithm over integer arrays.
    function automatic void arc4_ref(input logic [23:0] k, input int len,
                                     input logic [7:0] src [256], output logic [7:0] dst [256]);
        int s [256];
        int a, b, tmp, kb;
        for (int n = 0; n < 256; n++) begin
            s[n] = n;
            dst[n] = 8'h00;
        end
        b = 0;
        for (a = 0; a < 256; a++) begin
            kb = int'((k >> (8 * (2 - (a % 3)))) & 24'hFF);
            b = (b + s[a] + kb) % 256;
            tmp = s[a]; s[a] = s[b]; s[b] = tmp;
        end
        a = 0; b = 0;
        dst[0] = 8'(len);
        for (int n = 1; n <= len; n++) begin
            a = (a + 1) % 256;
            b = (b + s[a]) % 256;
            tmp = s[a]; s[a] = s[b]; s[b] = tmp;
            dst[n] = src[n] ^ 8'(s[(s[a] + s[b]) % 256]);
        end
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic load_vec();
        for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;
        for (int n = 0; n < 10; n++) pt_mem[n] = kv_pt[n];
    endtask

    task automatic push_vec();
        for (int n = 0; n < 10; n++) exp_q.push_back({8'(n), kv_ct[n]});
    endtask

    task automatic push_model(input logic [23:0] k, input int len);
        logic [7:0] out [256];
        arc4_ref(k, len, pt_mem, out);
        for (int n = 0; n <= len; n++) exp_q.push_back({8'(n), out[n]});
    endtask

    task automatic start_run(input logic [23:0] k);
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        key = $urandom;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (!rdy && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL %s_latency: rdy still 0 after %0d cycles, required within %0d", name, n, bound);
        end
        chk({name, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n0, bad, cyc, hi;
        int len;
        logic [23:0] rk;

        fork
            begin : monitor
                logic [15:0] e;
                forever begin
                    @(negedge clk);
                    if (ct_wren === 1'b1) begin
                        nwr++;
                        seen[ct_addr]++;
                        ct_mem[ct_addr] = ct_wrdata;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL ct_write_unexpected: addr=%0d data=%02h, no write expected", ct_addr, ct_wrdata);
                        end else begin
                            e = exp_q.pop_front();
                            if ({ct_addr, ct_wrdata} !== e) begin
                                errors++;
                                $display("FAIL ct_write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                                         ct_addr, ct_wrdata, e[15:8], e[7:0]);
                            end
                        end
                    end
                end
            end
        join_none

        rst = 1'b1; en = 1'b0; key = '0;
        for (int n = 0; n < 256; n++) begin
            pt_mem[n] = 8'h00; ct_mem[n] = 8'h00; seen[n] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_rdy", int'(rdy), 1);
        chk("reset_ct_wren", int'(ct_wren), 0);
        chk("reset_ct_addr", int'(ct_addr), 0);
        chk("reset_pt_addr", int'(pt_addr), 0);
        chk("reset_ct_wrdata", int'(ct_wrdata), 0);
        rst = 1'b0;

        // Known vector
        load_vec(); push_vec(); n0 = nwr;
        start_run(24'h4B6579);
        wait_done("vec1", 256 + 1536 + 8 * 9 + 8);
        chk("vec1_writes", nwr - n0, 10);

        // Zero length
        pt_mem[0] = 8'h00; exp_q.push_back(16'h0000); n0 = nwr;
        start_run($urandom);
        wait_done("len0", 256 + 1536 + 8);
        chk("len0_writes", nwr - n0, 1);

        // Reset mid-KSA, then rerun the known vector
        load_vec(); n0 = nwr;
        start_run(24'h4B6579);
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rdy", int'(rdy), 1);
        chk("midrst_ct_wren", int'(ct_wren), 0);
        repeat (100) @(negedge clk);
        chk("midrst_no_writes", nwr - n0, 0);
        push_vec(); n0 = nwr;
        start_run(24'h4B6579);
        wait_done("rerun", 256 + 1536 + 8 * 9 + 8);
        chk("rerun_writes", nwr - n0, 10);

        // Simultaneous rst and en: no run
        @(negedge clk);
        rst = 1'b1; en = 1'b1; key = 24'h4B6579;
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_en_rdy", int'(rdy), 1);
        n0 = nwr;
        repeat (50) @(negedge clk);
        chk("rst_en_no_writes", nwr - n0, 0);

        // en and key change while busy in PRGA
        push_vec(); n0 = nwr;
        start_run(24'h4B6579);
        cyc = 0;
        while (nwr == n0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_len_write_seen", int'(nwr > n0), 1);
        repeat (20) @(negedge clk);
        en = 1'b1; key = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        en = 1'b0;
        wait_done("busy", 256 + 1536 + 8 * 9 + 8);
        chk("busy_writes", nwr - n0, 10);
        repeat (100) @(negedge clk);
        chk("busy_no_second_run", nwr - n0, 10);
        chk("busy_rdy_idle", int'(rdy), 1);

        // en held high: two back-to-back runs
        push_vec(); n0 = nwr;
        @(negedge clk);
        key = 24'h4B6579; en = 1'b1;
        @(negedge clk);
        wait_done("held1", 256 + 1536 + 8 * 9 + 8);
        hi = 0;
        while (rdy && hi < 10) begin
            @(negedge clk);
            hi++;
        end
        chk("held_rdy_gap", hi, 1);
        push_vec();
        en = 1'b0;
        wait_done("held2", 256 + 1536 + 8 * 9 + 8);
        chk("held_writes", nwr - n0, 20);

        // Round trip with L=255
        pt_mem[0] = 8'd255;
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
        for (int n = 0; n < 256; n++) seen[n] = 0;
        push_model(24'h000018, 255);
        start_run(24'h000018);
        wait_done("rt", 256 + 1536 + 8 * 255 + 8);
        arc4_ref(24'h000018, 255, ct_mem, dec);
        bad = 0;
        for (int n = 1; n < 256; n++) if (dec[n] !== pt_mem[n]) bad++;
        chk("rt_decrypt_mismatches", bad, 0);
        bad = 0;
        for (int n = 0; n < 256; n++) if (seen[n] != 1) bad++;
        chk("rt_addr_coverage_bad", bad, 0);

        // Random keys and lengths
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(1, 40);
            rk  = $urandom;
            pt_mem[0] = 8'(len);
            for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
            push_model(rk, len); n0 = nwr;
            start_run(rk);
            wait_done("rand", 256 + 1536 + 8 * len + 8);
            chk("rand_writes", nwr - n0, len + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
